hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, meaning register index width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal 1..4, meaning the number of consecutive ID cycles a loaded register is unavailable after the load enters EX.
REQ-003 SHALL have parameter ZERO_REG, default 31, meaning the hardwired-zero register index, which never causes a hazard.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have ports ID_rs1 and ID_rs2, input, REG_W, the ID-stage source register indices.
REQ-007 SHALL have ports ID_use_rs1 and ID_use_rs2, input, 1, each asserted when that source is actually read (e.g. I-type clears ID_use_rs2).
REQ-008 SHALL have port EX_rd, input, REG_W, the EX-stage destination register.
REQ-009 SHALL have port EX_memRead, input, 1, asserted when EX holds a load.
REQ-010 SHALL have port MEM_branch_taken, input, 1, asserted when a taken branch resolves in MEM.
REQ-011 SHALL have port stall, output, 1, asserted for a load-use hazard.
REQ-012 SHALL have ports pc_we and ifid_we, output, 1, the PC and IF/ID write enables.
REQ-013 SHALL have port idex_bubble, output, 1, which zeroes the control signals entering ID/EX.
REQ-014 SHALL have port ifid_flush, output, 1, which clears IF/ID.
REQ-015 SHALL have port stall_cnt, output, 32, the stall-cycle count (see Configuration).

Function
REQ-016 SHALL define slot 0 as {valid = EX_memRead, rd = EX_rd}, taken combinationally from the inputs.
REQ-017 SHALL hold LOAD_LAT-1 registered shadow slots (none when LOAD_LAT = 1); each cycle slot k+1 takes slot k, and slot 1 takes slot 0.
REQ-018 SHALL shift the shadow slots every cycle regardless of stall or flush, because EX and later stages always advance (a stall inserts a bubble in EX).
REQ-019 SHALL compute hit = any valid slot whose rd differs from ZERO_REG and equals (ID_use_rs1 and ID_rs1) or (ID_use_rs2 and ID_rs2).
REQ-020 SHALL drive stall = hit and not MEM_branch_taken, combinationally, with zero-cycle latency.
REQ-021 SHALL drive pc_we = ifid_we = not stall.
REQ-022 SHALL drive idex_bubble = stall or MEM_branch_taken.
REQ-023 SHALL drive ifid_flush = MEM_branch_taken, giving flush priority over stall.
REQ-024 SHALL produce, for a dependent instruction held in ID, exactly LOAD_LAT consecutive stall cycles after its producing load enters EX.
REQ-025 SHALL count a hazard once per load when both ID sources match the same load, with no extra stall.
REQ-026 SHALL, when several slots hit, release stall only after the youngest matching load's window expires.
REQ-027 SHALL never let an unused source (ID_use_rsX = 0) cause a stall.

Reset
REQ-028 SHALL, while reset is high at a clock edge, clear all shadow slot valid bits and the stall counter to 0.
REQ-029 SHALL, during reset, still evaluate the outputs combinationally from slot 0: stall = 1 with a matching EX load, otherwise pc_we = 1, ifid_we = 1, idex_bubble = 0, ifid_flush = 0.
REQ-030 SHALL discard any load window in progress when reset is asserted mid-stall; no stall from the shadow slots persists after reset is released.

Configuration
REQ-031 SHALL, with macro HAZARD_CTRL_PERF_CNT_EN defined, increment stall_cnt by 1 on each clock edge where stall = 1, saturating at 32'hFFFF_FFFF (no wrap).
REQ-032 SHALL, without HAZARD_CTRL_PERF_CNT_EN, tie stall_cnt to 0 and instantiate no counter flops.

Verification
REQ-033 SHALL test LOAD_LAT=1 with EX load rd=3 and ID rs1=3 used: stall=1, pc_we=0, idex_bubble=1 for 1 cycle, then stall=0.
REQ-034 SHALL test LOAD_LAT=2 with a load rd=5 in EX and ID rs2=5 used held in ID: stall=1 for exactly 2 cycles, then 0; stall_cnt=2 with the macro defined.
REQ-035 SHALL test EX load rd=31 (ZERO_REG) against ID rs1=31: stall=0; and load rd=4 against ID rs2=4 with ID_use_rs2=0: stall=0.
REQ-036 SHALL test a hazard coinciding with MEM_branch_taken=1: stall=0, ifid_flush=1, idex_bubble=1, pc_we=1.
REQ-037 SHALL test LOAD_LAT=3 with reset asserted in the 2nd stall cycle: shadow cleared, stall=0 the cycle after reset drops with no EX load, stall_cnt=0.
REQ-038 SHALL test the counter preloaded to 32'hFFFF_FFFE followed by 3 stall cycles: stall_cnt holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Load-use hazard detection with a LOAD_LAT-deep load window and
//               branch-flush priority. HAZARD_CTRL_PERF_CNT_EN adds a
//               saturating stall-cycle counter on stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rs1,
    input  logic [REG_W-1:0] ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic [REG_W-1:0] EX_rd,
    input  logic             EX_memRead,
    input  logic             MEM_branch_taken,
    output logic             stall,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [31:0]      stall_cnt
);

    localparam logic [REG_W-1:0] c_ZERO_RD = REG_W'(ZERO_REG);

    logic [LOAD_LAT-1:0] w_slot_vld;
    logic [REG_W-1:0]    w_slot_rd [LOAD_LAT];
    logic                w_hit;
    logic                w_stall;

    assign w_slot_vld[0] = EX_memRead;
    assign w_slot_rd[0]  = EX_rd;

    // Shadow slots track loads that already left EX; they shift every cycle
    // because a stall only holds IF/ID while EX receives a bubble.
    generate
        if (LOAD_LAT > 1) begin : g_shadow
            logic [LOAD_LAT-1:1] r_vld;
            logic [REG_W-1:0]    r_rd [1:LOAD_LAT-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld <= '0;
                end else begin
                    r_vld[1] <= EX_memRead;
                    for (int k = 2; k < LOAD_LAT; k++) begin
                        r_vld[k] <= r_vld[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_rd[1] <= EX_rd;
                for (int k = 2; k < LOAD_LAT; k++) begin
                    r_rd[k] <= r_rd[k-1];
                end
            end

            for (genvar k = 1; k < LOAD_LAT; k++) begin : g_tap
                assign w_slot_vld[k] = r_vld[k];
                assign w_slot_rd[k]  = r_rd[k];
            end
        end
    endgenerate

    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (w_slot_vld[k] && (w_slot_rd[k] != c_ZERO_RD) &&
                ((ID_use_rs1 && (w_slot_rd[k] == ID_rs1)) ||
                 (ID_use_rs2 && (w_slot_rd[k] == ID_rs2)))) begin
                w_hit = 1'b1;
            end
        end
    end

    // A taken branch squashes the dependent instruction, so flush wins.
    assign w_stall     = w_hit && !MEM_branch_taken;
    assign stall       = w_stall;
    assign pc_we       = !w_stall;
    assign ifid_we     = !w_stall;
    assign idex_bubble = w_stall || MEM_branch_taken;
    assign ifid_flush  = MEM_branch_taken;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;

    generate
        if (LOAD_LAT == 1) begin : g_unused
            logic w_unused;
            assign w_unused = clk ^ reset;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench driving LOAD_LAT = 1, 2, 3 instances with
//               shared directed and random stimulus against a busy-register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int c_N   = 3;
    localparam int c_MAX = 32'hFFFF_FFFF;

    logic       clk;
    logic       reset;
    logic [4:0] ID_rs1, ID_rs2, EX_rd;
    logic       ID_use_rs1, ID_use_rs2, EX_memRead, MEM_branch_taken;

    logic [c_N-1:0] w_stall, w_pc_we, w_ifid_we, w_bubble, w_flush;
    logic [31:0]    w_cnt [c_N];

    int tests_run = 0;
    int tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .ZERO_REG(31)) u_lat1 (
        .clk(clk), .reset(reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
        .EX_memRead(EX_memRead), .MEM_branch_taken(MEM_branch_taken),
        .stall(w_stall[0]), .pc_we(w_pc_we[0]), .ifid_we(w_ifid_we[0]),
        .idex_bubble(w_bubble[0]), .ifid_flush(w_flush[0]), .stall_cnt(w_cnt[0]));

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .ZERO_REG(31)) u_lat2 (
        .clk(clk), .reset(reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
        .EX_memRead(EX_memRead), .MEM_branch_taken(MEM_branch_taken),
        .stall(w_stall[1]), .pc_we(w_pc_we[1]), .ifid_we(w_ifid_we[1]),
        .idex_bubble(w_bubble[1]), .ifid_flush(w_flush[1]), .stall_cnt(w_cnt[1]));

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .ZERO_REG(31)) u_lat3 (
        .clk(clk), .reset(reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
        .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2), .EX_rd(EX_rd),
        .EX_memRead(EX_memRead), .MEM_branch_taken(MEM_branch_taken),
        .stall(w_stall[2]), .pc_we(w_pc_we[2]), .ifid_we(w_ifid_we[2]),
        .idex_bubble(w_bubble[2]), .ifid_flush(w_flush[2]), .stall_cnt(w_cnt[2]));

    // Expected vector per instance: {stall, pc_we, ifid_we, idex_bubble, ifid_flush, stall_cnt}
    logic [36:0] expq [c_N][$];
    string       tagq [$];

    // Model state: cycle in which each register was last loaded in EX.
    int          cyc = 0;
    int          last_ld [c_N][32];
    logic [31:0] m_cnt [c_N];

    task automatic model_reset_windows();
        for (int i = 0; i < c_N; i++)
            for (int r = 0; r < 32; r++) last_ld[i][r] = -100;
    endtask

    function automatic logic busy(int i, logic [4:0] r);
        int lat = i + 1;
        if (r == 5'd31) return 1'b0;
        if (EX_memRead && EX_rd == r) return 1'b1;
        return (last_ld[i][r] >= cyc - lat + 1);
    endfunction

    task automatic drive(input string tag, input logic rst, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic br, input logic preload);
        logic hit, st;
        @(posedge clk);
        #1;
        reset = rst; EX_memRead = mr; EX_rd = rd; ID_rs1 = rs1; ID_use_rs1 = u1;
        ID_rs2 = rs2; ID_use_rs2 = u2; MEM_branch_taken = br;
`ifdef HAZARD_CTRL_PERF_CNT_EN
        if (preload) begin
            force u_lat1.r_stall_cnt = 32'hFFFF_FFFE;
            force u_lat2.r_stall_cnt = 32'hFFFF_FFFE;
            force u_lat3.r_stall_cnt = 32'hFFFF_FFFE;
            for (int i = 0; i < c_N; i++) m_cnt[i] = 32'hFFFF_FFFE;
        end
`endif
        for (int i = 0; i < c_N; i++) begin
            hit = (u1 && busy(i, rs1)) || (u2 && busy(i, rs2));
            st  = hit && !br;
            expq[i].push_back({st, !st, !st, st || br, br, m_cnt[i]});
`ifdef HAZARD_CTRL_PERF_CNT_EN
            if (rst) m_cnt[i] = 32'd0;
            else if (st && m_cnt[i] != c_MAX) m_cnt[i] = m_cnt[i] + 32'd1;
`endif
        end
        tagq.push_back(tag);
        if (rst) model_reset_windows();
        else if (mr) for (int i = 0; i < c_N; i++) last_ld[i][rd] = cyc;
        cyc++;
`ifdef HAZARD_CTRL_PERF_CNT_EN
        if (preload) begin
            @(negedge clk);
            #1;
            release u_lat1.r_stall_cnt;
            release u_lat2.r_stall_cnt;
            release u_lat3.r_stall_cnt;
        end
`endif
    endtask

    task automatic idle(input string tag, input logic rst);
        drive(tag, rst, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are valid every cycle, so compare once per cycle mid-period.
    always @(negedge clk) begin
        if (tagq.size() > 0) begin
            string t;
            t = tagq.pop_front();
            for (int i = 0; i < c_N; i++) begin
                logic [36:0] act, exp_v;
                exp_v = expq[i].pop_front();
                act   = {w_stall[i], w_pc_we[i], w_ifid_we[i], w_bubble[i], w_flush[i], w_cnt[i]};
                tests_run++;
                if (act !== exp_v) begin
                    tests_failed++;
                    $display("FAIL %s lat=%0d cyc=%0d: got stall/pcwe/ifidwe/bub/flush=%b cnt=%h, want %b cnt=%h",
                             t, i + 1, cyc, act[36:32], act[31:0], exp_v[36:32], exp_v[31:0]);
                end
            end
        end
    end

    initial begin
        int wait_cnt;
        reset = 1'b1; EX_memRead = 1'b0; EX_rd = '0; ID_rs1 = '0; ID_rs2 = '0;
        ID_use_rs1 = 1'b0; ID_use_rs2 = 1'b0; MEM_branch_taken = 1'b0;
        model_reset_windows();
        for (int i = 0; i < c_N; i++) m_cnt[i] = 32'd0;

        idle("reset", 1'b1);
        idle("reset", 1'b1);
        drive("reset_eval", 1'b1, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        idle("after_reset", 1'b0);

        drive("lu_rs1", 1'b0, 1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) drive("lu_rs1_hold", 1'b0, 1'b0, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

        idle("pre_rs2", 1'b1);
        drive("lu_rs2", 1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        repeat (3) drive("lu_rs2_hold", 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        idle("lu_rs2_cnt", 1'b0);

        drive("zero_reg", 1'b0, 1'b1, 5'd31, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) idle("gap", 1'b0);
        drive("unused_rs2", 1'b0, 1'b1, 5'd4, 5'd1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        repeat (2) drive("unused_rs2_hold", 1'b0, 1'b0, 5'd0, 5'd1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);

        drive("branch_prio", 1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) idle("gap", 1'b0);

        drive("both_src", 1'b0, 1'b1, 5'd6, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        repeat (3) drive("both_src_hold", 1'b0, 1'b0, 5'd0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);

        drive("multi_ld", 1'b0, 1'b1, 5'd2, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        drive("multi_ld2", 1'b0, 1'b1, 5'd2, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (4) drive("multi_hold", 1'b0, 1'b0, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

        idle("pre_midrst", 1'b1);
        drive("midrst_ld", 1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        drive("midrst_rst", 1'b1, 1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) drive("midrst_after", 1'b0, 1'b0, 5'd0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

        drive("sat_pre", 1'b0, 1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) drive("sat", 1'b0, 1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        idle("sat_end", 1'b0);
        idle("post_sat", 1'b1);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] a, b, d;
            a = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
            b = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
            d = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
            drive("random", ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), d,
                  a, 1'($urandom_range(0, 3) != 0), b, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), 1'b0);
        end

        wait_cnt = 0;
        while (tagq.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (tagq.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d entries left, want 0", tagq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
